// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: registered round-robin arbiter that drives the one-hot select lines of the A/B/C/D priority mux
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       valid,
  output logic       s1,
  output logic       s2,
  output logic       s3
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d, ptr_q, ptr_d, base, j, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic found, others, expired;
  // In GRANT the search starts after the owner; the owner itself is visited last
  always_comb begin
    base = state_q == GRANT ? idx_q : ptr_q;
    found = 1'b0;
    win = 2'd0;
    j = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      j = base + 2'(i);
      if (!found && req[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  assign others = |(req & ~gnt_q);
  assign expired = MAX_HOLD != 0 && cnt_q >= CNT_W'(MAX_HOLD);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE || !req[idx_q] || (expired && others)) begin
      if (state_q == GRANT) ptr_d = idx_q;
      state_d = found ? GRANT : IDLE;
      gnt_d = found ? 4'b0001 << win : 4'b0000;
      idx_d = win;
      cnt_d = found ? CNT_W'(1) : '0;
    end else if (MAX_HOLD != 0 && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 4'b0000;
      idx_q <= 2'd0;
      ptr_q <= 2'd3;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign gnt = gnt_q;
  assign idx = idx_q;
  assign valid = |gnt_q;
  assign s1 = gnt_q[1];
  assign s2 = gnt_q[2];
  assign s3 = gnt_q[3];
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: table-driven and sequence checks of the round-robin select arbiter (MAX_HOLD=4)
module tb_mux_sel_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, gnt;
  logic [1:0] idx;
  logic valid, s1, s2, s3;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic [3:0] g;
    logic [1:0] x;
  } vec_t;

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .idx(idx),
    .valid(valid), .s1(s1), .s2(s2), .s3(s3)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ex);
    logic [9:0] act, exp;
    act = {gnt, idx, valid, s3, s2, s1};
    exp = {eg, ex, |eg, eg[3], eg[2], eg[1]};
    checks++;
    if (act !== exp || (s1 + s2 + s3) > 1) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b s3s2s1=%b%b%b, want gnt=%b idx=%0d valid=%b s3s2s1=%b%b%b",
               name, gnt, idx, valid, s3, s2, s1, eg, ex, |eg, eg[3], eg[2], eg[1]);
    end
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1'b1, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b1010, 4'b0010, 2'd1},
      '{1'b0, 4'b1010, 4'b0010, 2'd1},
      '{1'b0, 4'b1000, 4'b1000, 2'd3},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0001, 4'b0001, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b1, 4'b1111, 4'b0000, 2'd0},
      '{1'b0, 4'b1111, 4'b0001, 2'd0},
      '{1'b0, 4'b1110, 4'b0010, 2'd1},
      '{1'b0, 4'b1100, 4'b0100, 2'd2},
      '{1'b0, 4'b1101, 4'b0100, 2'd2},
      '{1'b0, 4'b1001, 4'b1000, 2'd3},
      '{1'b0, 4'b0000, 4'b0000, 2'd0},
      '{1'b0, 4'b0111, 4'b0001, 2'd0},
      '{1'b0, 4'b0000, 4'b0000, 2'd0}
    };
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q);
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].x);
    end
    // B and C alternate in blocks of MAX_HOLD cycles
    step(1'b1, 4'b0110);
    check("rst_before_timeout", 4'b0000, 2'd0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b0110);
      check($sformatf("timeout%0d", k), ((k / 4) % 2) ? 4'b0100 : 4'b0010, ((k / 4) % 2) ? 2'd2 : 2'd1);
    end
    // Lone owner past MAX_HOLD keeps the grant with no glitch
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b0100);
      check($sformatf("saturate%0d", k), 4'b0100, 2'd2);
    end
    step(1'b0, 4'b0000);
    check("release_idle", 4'b0000, 2'd0);
    // Timeout hands off even to a lower-index source after wrap
    step(1'b0, 4'b1000);
    check("d_grant", 4'b1000, 2'd3);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1001);
      check($sformatf("d_hold%0d", k), 4'b1000, 2'd3);
    end
    step(1'b0, 4'b1001);
    check("d_timeout_to_a", 4'b0001, 2'd0);
    // Reset while D owns the mux
    step(1'b0, 4'b1000);
    check("a_release_to_d", 4'b1000, 2'd3);
    step(1'b1, 4'b1000);
    check("rst_mid_grant", 4'b0000, 2'd0);
    step(1'b0, 4'b1000);
    check("regrant_after_rst", 4'b1000, 2'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
